// File: rtl/sdf_cplx_delay_pkg.sv
// Shared types and constants for the SDF complex delay line.
package sdf_pkg;

    // Default sample width for each of the real and imaginary parts.
    localparam int SDF_W = 24;

    // Delay-line control state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One complex sample at the default width.
    typedef struct packed {
        logic signed [SDF_W-1:0] re;
        logic signed [SDF_W-1:0] im;
    } cplx_t;

    // An out-of-range requested length falls back to the full line.
    function automatic int sdf_clamp_len(input int sel, input int depth);
        return (sel == 0 || sel > depth) ? depth : sel;
    endfunction

endpackage

// File: rtl/sdf_cplx_delay_if.sv
// Stream bundle of the SDF complex delay line: tagged I/Q in, oldest entry out.
interface sdf_cplx_delay_if
    import sdf_pkg::*;
#(
    parameter int WIDTH = SDF_W,
    parameter int DEPTH = 4
);
    logic                       in_valid;
    logic signed [WIDTH-1:0]    din_r;
    logic signed [WIDTH-1:0]    din_i;
    logic signed [WIDTH-1:0]    dout_r;
    logic signed [WIDTH-1:0]    dout_i;
    logic                       out_valid;
    logic [$clog2(DEPTH)-1:0]   phase;
    logic                       draining;

    // Sample source / phase consumer side.
    modport master (
        output in_valid, din_r, din_i,
        input  dout_r, dout_i, out_valid, phase, draining
    );

    // Delay line side.
    modport slave (
        input  in_valid, din_r, din_i,
        output dout_r, dout_i, out_valid, phase, draining
    );
endinterface

// File: rtl/sdf_shift_lane.sv
// One shift register lane with a runtime-selectable output tap.
// Entry 0 holds the newest word; every shift moves all DEPTH entries by one.
module sdf_shift_lane #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(DEPTH)-1:0] tap,
    output logic [WIDTH-1:0]         dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Shift the whole line on enable; pure concatenation, no arithmetic between entries.
    // NOTE: the storage is reset because the output must read zero the instant reset asserts,
    // which keeps this in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (shift) begin
            mem[0] <= din;
            for (int k = 1; k < DEPTH; k++) mem[k] <= mem[k-1];
        end
    end

    // Tap select comes from registered state only, so there is no input-to-output path.
    assign dout = mem[tap];
endmodule

// File: rtl/sdf_cplx_delay.sv
// Complex-sample delay line for radix-2 SDF FFT stages.
// Delays a tagged I/Q stream by L shifts, drains itself with zeros when input stops,
// and supplies the stage phase counter (shift count modulo L).
// Optional feature: define SDF_DLY_RUNTIME_LEN_EN to add a len_sel port that picks L
// at the start of each burst; otherwise L = DEPTH.
module sdf_cplx_delay
    import sdf_pkg::*;
#(
    parameter int WIDTH = SDF_W,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SDF_DLY_RUNTIME_LEN_EN
    input  logic [$clog2(DEPTH):0] len_sel,
`endif
    sdf_cplx_delay_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    state_t          state_q, state_d;
    logic [LW-1:0]   drain_q, drain_d;
    logic [LW-1:0]   len_cur;
    logic [LW-1:0]   phase_inc;
    logic [PW-1:0]   phase_q, phase_d;
    logic [PW-1:0]   tap;
    logic            draining_q;
    logic            shift;
    logic [WIDTH:0]  push_r, lane_r;
    logic [WIDTH-1:0] push_i, lane_i;

`ifdef SDF_DLY_RUNTIME_LEN_EN
    logic [LW-1:0] len_q, len_new;

    assign len_new = LW'(sdf_clamp_len(int'(len_sel), DEPTH));
    // The starting edge already counts with the newly requested length.
    assign len_cur = (state_q == ST_IDLE) ? len_new : len_q;
    assign tap     = PW'(len_q - LW'(1));

    // Latch the effective length only when a burst starts; mid-burst changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   len_q <= LW'(DEPTH);
        else if (state_q == ST_IDLE && bus.in_valid)  len_q <= len_new;
    end
`else
    assign len_cur = LW'(DEPTH);
    assign tap     = PW'(DEPTH - 1);
`endif

    assign shift     = bus.in_valid | (state_q != ST_IDLE);
    assign push_r    = bus.in_valid ? {1'b1, bus.din_r} : '0;
    assign push_i    = bus.in_valid ? bus.din_i : '0;
    assign phase_inc = {1'b0, phase_q} + LW'(1);

    // Next state, drain count and phase.
    // NOTE: every output of this block gets a default first so no path leaves it unassigned,
    // which is what keeps synthesis from inferring latches.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        phase_d = phase_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end
            end
            ST_RUN: begin
                if (!bus.in_valid) begin
                    // A one-entry line is already flushed by this single zero shift.
                    state_d = (len_cur == LW'(1)) ? ST_IDLE : ST_DRAIN;
                    drain_d = (len_cur == LW'(1)) ? '0 : LW'(1);
                end
            end
            ST_DRAIN: begin
                if (bus.in_valid) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else if (drain_q + LW'(1) >= len_cur) begin
                    state_d = ST_IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + LW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                drain_d = '0;
            end
        endcase
        if (state_d == ST_IDLE)  phase_d = '0;
        else if (shift)          phase_d = (phase_inc == len_cur) ? '0 : phase_inc[PW-1:0];
    end

    // Control registers; draining is registered so it never glitches on in_valid.
    // NOTE: sequential state uses non-blocking assignments so all registers update together
    // from the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            phase_q    <= '0;
            draining_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            phase_q    <= phase_d;
            draining_q <= (state_d == ST_DRAIN);
        end
    end

    // Real lane carries the valid tag in its MSB.
    sdf_shift_lane #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_lane_r (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (shift),
        .din   (push_r),
        .tap   (tap),
        .dout  (lane_r)
    );

    sdf_shift_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_i (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (shift),
        .din   (push_i),
        .tap   (tap),
        .dout  (lane_i)
    );

    assign bus.dout_r    = lane_r[WIDTH-1:0];
    assign bus.out_valid = lane_r[WIDTH];
    assign bus.dout_i    = lane_i;
    assign bus.phase     = phase_q;
    assign bus.draining  = draining_q;
endmodule

// File: tb/tb_sdf_cplx_delay.sv
// Scoreboard bench for sdf_cplx_delay: the driver predicts each post-edge output from a
// history-of-pushes model and queues it; a monitor pops and compares after every edge.
module tb_sdf_cplx_delay;
    import sdf_pkg::*;

    localparam int W = SDF_W;
`ifdef SDF_DLY_RUNTIME_LEN_EN
    localparam int D = 8;
`else
    localparam int D = 4;
`endif
    localparam int PW = $clog2(D);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdf_cplx_delay_if #(.WIDTH(W), .DEPTH(D)) bus ();
`ifdef SDF_DLY_RUNTIME_LEN_EN
    logic [PW:0] len_sel;
`endif

    sdf_cplx_delay #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef SDF_DLY_RUNTIME_LEN_EN
        .len_sel (len_sel),
`endif
        .bus     (bus)
    );

    typedef struct packed {
        logic  v;
        cplx_t s;
    } word_t;

    typedef struct {
        word_t w;
        int    phase;
        logic  draining;
    } exp_t;

    exp_t  exp_q[$];
    word_t hist[$];       // every word pushed, oldest first (last D kept)
    bit    busy;          // line is shifting on its own
    int    zrun;          // consecutive zero shifts while busy
    int    pcount;        // shifts since the burst started
    int    l_run;         // length in force for the current burst
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int clamp(input int s);
        return (s < 1 || s > D) ? D : s;
    endfunction

    task automatic model_reset();
        hist.delete();
        busy   = 0;
        zrun   = 0;
        pcount = 0;
        l_run  = D;
    endtask

    // Predict the state visible after the coming clock edge.
    task automatic model_step(input bit v, input logic signed [W-1:0] r,
                              input logic signed [W-1:0] i, input int sel);
        word_t w;
        exp_t  e;
        if (v && !busy) begin
`ifdef SDF_DLY_RUNTIME_LEN_EN
            l_run = clamp(sel);
`else
            l_run = D + 0 * sel;
`endif
            pcount = 0;
        end
        if (v || busy) begin
            w.v    = v;
            w.s.re = v ? r : '0;
            w.s.im = v ? i : '0;
            hist.push_back(w);
            if (hist.size() > D) void'(hist.pop_front());
            pcount++;
            if (v) begin
                busy = 1;
                zrun = 0;
            end else begin
                zrun++;
                if (zrun >= l_run) begin
                    busy   = 0;
                    zrun   = 0;
                    pcount = 0;
                end
            end
        end
        e.w        = (hist.size() >= l_run) ? hist[hist.size() - l_run] : '0;
        e.phase    = busy ? (pcount % l_run) : 0;
        e.draining = busy && (zrun > 0);
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs, queue the prediction, step past the edge.
    task automatic cycle(input bit v, input logic signed [W-1:0] r,
                         input logic signed [W-1:0] i, input int sel);
        bus.in_valid = v;
        // Invalid cycles carry junk data that must never enter the line.
        bus.din_r    = v ? r : W'($urandom);
        bus.din_i    = v ? i : W'($urandom);
`ifdef SDF_DLY_RUNTIME_LEN_EN
        len_sel      = (PW+1)'(sel);
`endif
        model_step(v, r, i, sel);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout_r"},    64'(bus.dout_r),    64'd0);
        check({tag, "_dout_i"},    64'(bus.dout_i),    64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_phase"},     64'(bus.phase),     64'd0);
        check({tag, "_draining"},  64'(bus.draining),  64'd0);
    endtask

    // Monitor: compare the DUT against each queued prediction shortly after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", 64'(bus.out_valid), 64'(e.w.v));
                check("dout_r",    64'(bus.dout_r),    64'(e.w.s.re));
                check("dout_i",    64'(bus.dout_i),    64'(e.w.s.im));
                check("phase",     64'(bus.phase),     64'(e.phase));
                check("draining",  64'(bus.draining),  64'(e.draining));
            end
        end
    end

    initial begin : driver
        logic signed [W-1:0] vmin, vmax;
        vmin = {1'b1, {(W-1){1'b0}}};
        vmax = {1'b0, {(W-1){1'b1}}};
        model_reset();
        bus.in_valid = 1'b0;
        bus.din_r    = '0;
        bus.din_i    = '0;
`ifdef SDF_DLY_RUNTIME_LEN_EN
        len_sel      = '0;
`endif
        repeat (2) @(posedge clk);
        #2;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Continuous input 1..8, then drain and sit idle.
        for (int k = 1; k <= 8; k++) cycle(1'b1, W'(k), -W'(k), 0);
        idle(D + 3);

        // Three samples then stop: drain flushes them and returns to idle.
        cycle(1'b1, W'(10), W'(11), 0);
        cycle(1'b1, W'(20), W'(21), 0);
        cycle(1'b1, W'(30), W'(31), 0);
        idle(D + 3);

        // Two-cycle gap inside a stream re-enters RUN from DRAIN.
        for (int k = 1; k <= 3; k++) cycle(1'b1, W'(100 + k), W'(200 + k), 0);
        idle(2);
        for (int k = 4; k <= 6; k++) cycle(1'b1, W'(100 + k), W'(200 + k), 0);
        idle(D + 3);

        // Full-scale extremes must come out bit-exact next to ordinary neighbours.
        cycle(1'b1, W'(5), W'(-5), 0);
        cycle(1'b1, vmin, vmax, 0);
        cycle(1'b1, vmax, vmin, 0);
        cycle(1'b1, W'(-1), W'(1), 0);
        idle(D + 3);

`ifdef SDF_DLY_RUNTIME_LEN_EN
        // Short length 2; a request for 8 mid-burst must be ignored.
        for (int k = 0; k < 5; k++) cycle(1'b1, W'(300 + k), W'(k), 2);
        for (int k = 0; k < 5; k++) cycle(1'b1, W'(400 + k), W'(k), 8);
        idle(D + 3);
        for (int k = 0; k < 10; k++) cycle(1'b1, W'(500 + k), W'(k), 8);
        idle(D + 3);
`endif

        // Randomised traffic with varying density and occasional long gaps.
        for (int blk = 0; blk < 8; blk++) begin
            int pct;
            int sel;
            pct = 30 + 10 * blk;
            sel = int'($urandom_range(0, D));
            for (int k = 0; k < 50; k++) begin
                bit v;
                v = ($urandom_range(0, 99) < pct);
                cycle(v, W'($urandom), W'($urandom), sel);
                if ($urandom_range(0, 9) == 0) sel = int'($urandom_range(0, D));
            end
            if (blk % 3 == 0) idle(D + 2);
        end

        // Asynchronous reset between edges in the middle of a stream.
        for (int k = 0; k < 3; k++) cycle(1'b1, W'(700 + k), W'(800 + k), 0);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        bus.in_valid = 1'b1;
        bus.din_r    = W'(999);
        @(posedge clk);
        #2;
        check_zero("midrst_hold");
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) cycle(1'b1, W'(900 + k), W'(-900 - k), 0);
        idle(D + 3);

        // Let the monitor drain anything outstanding, within a bound.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
